// File: rtl/onehot_grant_decoder.sv
// onehot_grant_decoder
// Receiving end of the priority-grant path. Validates one-hot grant vectors, decodes
// them to a binary index and buffers the result in a small FIFO with valid/ready on
// both sides. Illegal codes are flagged per entry and counted in a saturating counter.
module onehot_grant_decoder #(
    parameter int N     = 3,
    parameter int IDXW  = 2,
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_grant,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    out_onehot,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            err_clr,
    output logic [ERRW-1:0] err_count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    // Decoded view of the incoming grant
    logic [IDXW-1:0] decIdx;
    logic [N-1:0]    decOnehot;
    logic            decErr;
    logic            anySet;
    logic            multiSet;

    // FIFO storage, one entry per accepted grant
    logic [IDXW-1:0] idxMem [DEPTH];
    logic [N-1:0]    ohMem  [DEPTH];
    logic            errMem [DEPTH];

    // Pointer, occupancy and handshake state
    logic [PTRW-1:0] wrPtr_q, wrPtr_d;
    logic [PTRW-1:0] rdPtr_q, rdPtr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic [ERRW-1:0] errCount_q, errCount_d;

    logic            push;
    logic            pop;

    // in_ready comes from a register so a consumer pop never reaches the producer
    // combinationally; both handshake outputs are forced low while reset is held.
    assign in_ready  = ready_q & ~rst;
    assign out_valid = (count_q != '0) & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head entry drives the consumer directly from storage
    assign out_idx    = idxMem[rdPtr_q];
    assign out_onehot = ohMem[rdPtr_q];
    assign out_err    = errMem[rdPtr_q];
    assign err_count  = errCount_q;

    // Validate the grant: the highest set bit wins, anything other than exactly one bit is an error
    always_comb begin
        decIdx    = '0;
        anySet    = |in_grant;
        multiSet  = |(in_grant & (in_grant - N'(1)));
        for (int i = 0; i < N; i++) begin
            if (in_grant[i]) begin
                decIdx = IDXW'(i);
            end
        end
        decErr    = ~anySet | multiSet;
        decOnehot = anySet ? (N'(1) << decIdx) : '0;
    end

    // Write the decoded entry into the slot at the write pointer on a push
    always_ff @(posedge clk) begin
        if (push) begin
            idxMem[wrPtr_q] <= decIdx;
            ohMem[wrPtr_q]  <= decOnehot;
            errMem[wrPtr_q] <= decErr;
        end
    end

    // Next-state for pointers and occupancy; power-of-two depth makes pointers wrap naturally
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTRW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNTW'(DEPTH));
    end

    // Register FIFO bookkeeping; reset empties the FIFO and leaves it ready to accept
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    // Error counter next-state: clear beats a same-cycle increment, increments stop at all-ones
    always_comb begin
        errCount_d = errCount_q;
        if (err_clr) begin
            errCount_d = '0;
        end else if (push && decErr && (errCount_q != {ERRW{1'b1}})) begin
            errCount_d = errCount_q + ERRW'(1);
        end
    end

    // Register the error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            errCount_q <= '0;
        end else begin
            errCount_q <= errCount_d;
        end
    end

endmodule
